// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SETTLE_W = 4;

    function automatic int n_vec(input int n_in);
        return 32'sd1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that holds each vector for SETTLE extra cycles.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != {SETTLE_W{1'b0}})) begin
            cnt_d = cnt_q - {{(SETTLE_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q <= {SETTLE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {SETTLE_W{1'b0}});

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a small combinational DUT and packs its
// sampled output into a truth table with a minterm count.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      areset_n,
    input  logic                      start,
    output logic [N_IN-1:0]           x_out,
    input  logic                      f_in,
    output logic                      busy,
    output logic                      done,
    output logic                      table_valid,
    output logic [n_vec(N_IN)-1:0]    tt,
    output logic [N_IN:0]             ones
);

    localparam int              N_VEC    = n_vec(N_IN);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(N_VEC - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_VEC-1:0]  tt_q, tt_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic              valid_q, valid_d;
    logic [N_IN-1:0]   x_out_q, x_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timer_load_s;
    logic              timer_en_s;
    logic              settle_zero_s;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .areset_n (areset_n),
        .load_i   (timer_load_s),
        .en_i     (timer_en_s),
        .zero_o   (settle_zero_s)
    );

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tt_d         = tt_q;
        ones_d       = ones_q;
        valid_d      = valid_q;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SWEEP;
                    idx_d        = {N_IN{1'b0}};
                    tt_d         = {N_VEC{1'b0}};
                    ones_d       = {(N_IN+1){1'b0}};
                    valid_d      = 1'b0;
                    timer_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                timer_en_s = 1'b1;
                if (settle_zero_s) begin
                    tt_d[idx_q] = f_in;
                    ones_d      = ones_q + (N_IN+1)'(f_in);
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        idx_d        = idx_q + N_IN'(1);
                        timer_load_s = 1'b1;
                    end
                end else begin
                    state_d = SWEEP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the edge.
        busy_d  = (state_d == SWEEP);
        done_d  = (state_d == DONE);
        x_out_d = busy_d ? idx_d : {N_IN{1'b0}};
    end

    // State, datapath and output registers; reset discards any partial table.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            idx_q   <= {N_IN{1'b0}};
            tt_q    <= {N_VEC{1'b0}};
            ones_q  <= {(N_IN+1){1'b0}};
            valid_q <= 1'b0;
            x_out_q <= {N_IN{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            x_out_q <= x_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_out       = x_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_valid = valid_q;
    assign tt          = tt_q;
    assign ones        = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (SETTLE=1 and SETTLE=0) driving behavioural DUT functions.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [1:0] mode_a, mode_b;
    logic [2:0] x_a, x_b;
    logic       f_a, f_b;
    logic       busy_a, busy_b, done_a, done_b, valid_a, valid_b;
    logic [7:0] tt_a, tt_b;
    logic [3:0] ones_a, ones_b;

    int n_checks;
    int n_errors;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .areset_n(rst_n), .start(start_a), .x_out(x_a), .f_in(f_a),
        .busy(busy_a), .done(done_a), .table_valid(valid_a), .tt(tt_a), .ones(ones_a)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0)) dut_b (
        .clk(clk), .areset_n(rst_n), .start(start_b), .x_out(x_b), .f_in(f_b),
        .busy(busy_b), .done(done_b), .table_valid(valid_b), .tt(tt_b), .ones(ones_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: (~x3&x2)|(x3&x1), 1: x1^x2^x3, 2: const 0, 3: const 1
    function automatic logic fmodel(input logic [1:0] m, input logic [2:0] x);
        case (m)
            2'd0:    return (~x[2] & x[1]) | (x[2] & x[0]);
            2'd1:    return ^x;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign f_a = fmodel(mode_a, x_a);
    assign f_b = fmodel(mode_b, x_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full sweep on one DUT, checked every cycle from cycle 0 to two cycles past done.
    task automatic sweep(input bit sel, input logic [1:0] m, input logic [7:0] et,
                         input logic [3:0] eo, input string tag);
        int per;
        int last;
        logic [2:0] xe;
        per  = sel ? 1 : 2;
        last = 8 * per;
        if (sel) mode_b = m; else mode_a = m;
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clk);
            xe = (c >= 1 && c <= last) ? 3'((c - 1) / per) : 3'd0;
            check({tag, "_x"},    sel ? x_b : x_a, xe);
            check({tag, "_busy"}, sel ? busy_b : busy_a, (c >= 1 && c <= last));
            check({tag, "_done"}, sel ? done_b : done_a, (c == last + 1));
            if (c >= last + 1) begin
                check({tag, "_tt"},    sel ? tt_b : tt_a, et);
                check({tag, "_ones"},  sel ? ones_b : ones_a, eo);
                check({tag, "_valid"}, sel ? valid_b : valid_a, 1'b1);
            end
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] xe;
        logic       be;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        mode_a   = 2'd0;
        mode_b   = 2'd1;

        // Reset held while start and f_in toggle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start_a = ~start_a;
            start_b = ~start_b;
            mode_a  = (i % 2 == 0) ? 2'd3 : 2'd2;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_x",     x_a, 3'd0);
        check("rst_busy",  busy_a, 1'b0);
        check("rst_done",  done_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_tt",    tt_a, 8'h00);
        check("rst_ones",  ones_a, 4'd0);
        check("rst_tt_b",  tt_b, 8'h00);

        sweep(1'b0, 2'd0, 8'hAC, 4'd4, "ref");
        sweep(1'b1, 2'd1, 8'h96, 4'd4, "xor_s0");
        sweep(1'b0, 2'd2, 8'h00, 4'd0, "const0");
        sweep(1'b0, 2'd3, 8'hFF, 4'd8, "const1");

        // Extra starts at cycles 5 and 17, accepted start at 18, async reset in cycle 25.
        mode_a = 2'd0;
        @(posedge clk); #1;
        for (int c = 0; c <= 25; c++) begin
            start_a = (c == 0 || c == 5 || c == 17 || c == 18);
            @(negedge clk);
            if (c >= 1 && c <= 16)       begin xe = 3'((c - 1) / 2);  be = 1'b1; end
            else if (c >= 19)            begin xe = 3'((c - 19) / 2); be = 1'b1; end
            else                         begin xe = 3'd0;             be = 1'b0; end
            check("busy_x",    x_a, xe);
            check("busy_busy", busy_a, be);
            check("busy_done", done_a, (c == 17));
            if (c == 17) check("busy_tt17", tt_a, 8'hAC);
            if (c == 18) check("busy_valid18", valid_a, 1'b1);
            if (c == 19) begin
                check("restart_tt", tt_a, 8'h00);
                check("restart_valid", valid_a, 1'b0);
            end
            if (c == 25) begin
                check("pre_rst_tt", tt_a, 8'h04);
                #2;
                rst_n = 1'b0;
                #1;
                check("arst_busy", busy_a, 1'b0);
                check("arst_x",    x_a, 3'd0);
                check("arst_tt",   tt_a, 8'h00);
                check("arst_ones", ones_a, 4'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_done", done_a, 1'b0);
            check("post_rst_busy", busy_a, 1'b0);
        end
        sweep(1'b0, 2'd0, 8'hAC, 4'd4, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
